mmio_input_reader: RTL and testbench



---
 rtl/mmio_input_reader.sv | 134 +++++++++++++
 tb/tb_mmio_input_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_input_reader.sv
// Memory-mapped reader for board switches and buttons: 2-flop synchronisers,
// per-input debounce, W1C button-press events and a saturating press counter.
module mmio_input_reader #(
    parameter logic [31:0] BASE_ADDR       = 32'h10020000,
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTN         = 5,
    parameter int          DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [31:0]        addr,
    input  logic               we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               hit,
    output logic               irq
);

    localparam int NUM_IN = NUM_SW + NUM_BTN;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Switches occupy the low bits, buttons the high bits of every per-input vector.
    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] s1;
    logic [NUM_IN-1:0] s2;
    logic [NUM_IN-1:0] stable;
    logic [CW-1:0]     cnt [NUM_IN];

    logic [NUM_SW-1:0]  stable_sw;
    logic [NUM_BTN-1:0] stable_btn;
    logic [NUM_BTN-1:0] stable_btn_d;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] btn_event;
    logic [NUM_BTN-1:0] btn_event_next;
    logic [15:0]        press_count;
    logic [15:0]        press_count_next;
    logic [4:0]         rise_cnt;
    logic [16:0]        count_sum;

    logic wr_hit;
    logic wr_event;
    logic wr_count;

    assign raw        = {btn_in, sw_in};
    assign stable_sw  = stable[NUM_SW-1:0];
    assign stable_btn = stable[NUM_IN-1:NUM_SW];
    assign rise       = stable_btn & ~stable_btn_d;

    assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_hit   = we & hit;
    assign wr_event = wr_hit && (addr[3:2] == 2'd2);
    assign wr_count = wr_hit && (addr[3:2] == 2'd3);

    logic unused_ok;
    assign unused_ok = ^{addr[1:0], wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            // A mismatch must persist DEBOUNCE_CYCLES cycles before it is accepted.
            for (int i = 0; i < NUM_IN; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rise_cnt = rise_cnt + 5'(rise[i]);
        end
    end

    assign count_sum = {1'b0, press_count} + 17'(rise_cnt);

    always_comb begin
        btn_event_next = btn_event;
        if (wr_event) begin
            btn_event_next = btn_event & ~wdata[NUM_BTN-1:0];
        end
        // A fresh rise beats a simultaneous clear.
        btn_event_next = btn_event_next | rise;

        press_count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        if (wr_count) begin
            press_count_next = 16'(rise_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_btn_d <= '0;
            btn_event    <= '0;
            press_count  <= '0;
            irq          <= 1'b0;
        end else begin
            stable_btn_d <= stable_btn;
            btn_event    <= btn_event_next;
            press_count  <= press_count_next;
            irq          <= |btn_event;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (addr[3:2])
                2'd0:    rdata[NUM_SW-1:0]  = stable_sw;
                2'd1:    rdata[NUM_BTN-1:0] = stable_btn;
                2'd2:    rdata[NUM_BTN-1:0] = btn_event;
                default: rdata[15:0]        = press_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_input_reader.sv
// Bench for mmio_input_reader with a short debounce window; a negedge monitor
// compares {hit, irq, rdata} against a queue filled by the driver.
`timescale 1ns/1ps
module tb_mmio_input_reader;

  localparam logic [31:0] BASE = 32'h10020000;
  localparam logic [31:0] SW_A = BASE;
  localparam logic [31:0] BS_A = BASE + 32'h4;
  localparam logic [31:0] EV_A = BASE + 32'h8;
  localparam logic [31:0] PC_A = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  logic [33:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  mmio_input_reader #(
    .BASE_ADDR(BASE), .NUM_SW(16), .NUM_BTN(5), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .btn_in(btn_in),
    .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .hit(hit), .irq(irq)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // Observe the current cycle at addr a, then advance one rising edge.
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] exp_rd,
                     input logic exp_irq, input logic exp_hit = 1'b1);
    addr = a;
    we   = 1'b0;
    exp_q.push_back({exp_hit, exp_irq, exp_rd});
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    we    = 1'b1;
    wdata = d;
    @(posedge clk); #1;
    we    = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [33:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if ({hit, irq, rdata} !== e) begin
        n_err++;
        $display("FAIL %s: got hit=%b irq=%b rdata=%h, want hit=%b irq=%b rdata=%h",
                 nm, hit, irq, rdata, e[33], e[32], e[31:0]);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    sw_in  = 16'hFFFF;
    btn_in = '0;
    addr   = BASE;
    we     = 1'b0;
    wdata  = '0;
    @(posedge clk); #1;

    // reset state and exact switch latency
    chk("rst_sw", SW_A, 32'h0, 1'b0);
    chk("rst_ev", EV_A, 32'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) chk("sw_latency_hold", SW_A, 32'h0, 1'b0);
    chk("sw_latency_set", SW_A, 32'h0000FFFF, 1'b0);

    // 3-cycle glitch on btn[2] is rejected
    btn_in = 5'b00100;
    for (int i = 0; i < 3; i++) chk("glitch_state_on", BS_A, 32'h0, 1'b0);
    btn_in = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      chk("glitch_state", BS_A, 32'h0, 1'b0);
      chk("glitch_event", EV_A, 32'h0, 1'b0);
    end

    // clean press of btn[2], event, irq, count, W1C clear
    btn_in = 5'b00100;
    for (int i = 0; i < 6; i++) chk("press_wait", BS_A, 32'h0, 1'b0);
    chk("press_state", BS_A, 32'h4, 1'b0);
    chk("press_event", EV_A, 32'h4, 1'b0);
    chk("press_irq",   EV_A, 32'h4, 1'b1);
    chk("press_count", PC_A, 32'h1, 1'b1);
    wr(EV_A, 32'h4);
    chk("w1c_event", EV_A, 32'h0, 1'b1);
    chk("w1c_irq",   PC_A, 32'h1, 1'b0);

    // btn[0] rise collides with a W1C of bit 0: set wins
    btn_in = 5'b00101;
    for (int i = 0; i < 6; i++) chk("coll_wait", BS_A, 32'h4, 1'b0);
    wr(EV_A, 32'h1);
    chk("coll_event", EV_A, 32'h1, 1'b0);
    chk("coll_irq",   EV_A, 32'h1, 1'b1);

    // release all, clear count and events
    btn_in = 5'b00000;
    for (int i = 0; i < 6; i++) chk("rel_wait", BS_A, 32'h5, 1'b1);
    chk("rel_state", BS_A, 32'h0, 1'b1);
    chk("rel_no_event", EV_A, 32'h1, 1'b1);
    wr(PC_A, 32'h0);
    wr(EV_A, 32'h1F);
    chk("clr_event", EV_A, 32'h0, 1'b1);
    chk("clr_count", PC_A, 32'h0, 1'b0);

    // saturation: preload 0xFFFE, two simultaneous rises
    force dut.press_count = 16'hFFFE;
    #1;
    release dut.press_count;
    chk("preload", PC_A, 32'h0000FFFE, 1'b0);
    btn_in = 5'b00011;
    for (int i = 0; i < 6; i++) chk("sat_wait", BS_A, 32'h0, 1'b0);
    chk("sat_state", BS_A, 32'h3, 1'b0);
    chk("sat_count", PC_A, 32'h0000FFFF, 1'b0);
    chk("sat_event", EV_A, 32'h3, 1'b1);

    // count write during a single rise loads 1
    btn_in = 5'b00000;
    for (int i = 0; i < 6; i++) chk("rel2_wait", BS_A, 32'h3, 1'b1);
    chk("rel2_state", BS_A, 32'h0, 1'b1);
    wr(EV_A, 32'h3);
    chk("clr2_event", EV_A, 32'h0, 1'b1);
    chk("clr2_count", PC_A, 32'h0000FFFF, 1'b0);
    btn_in = 5'b00100;
    for (int i = 0; i < 6; i++) chk("wrc_wait", BS_A, 32'h0, 1'b0);
    wr(PC_A, 32'hDEADBEEF);
    chk("wrc_count", PC_A, 32'h1, 1'b0);
    chk("wrc_event", EV_A, 32'h4, 1'b1);

    // address decode and read-only registers
    chk("miss_above", 32'h10020010, 32'h0, 1'b1, 1'b0);
    chk("miss_below", 32'h1001FFFC, 32'h0, 1'b1, 1'b0);
    chk("byte_offset", BASE + 32'h2, 32'h0000FFFF, 1'b1, 1'b1);
    wr(SW_A, 32'h0);
    chk("ro_sw", SW_A, 32'h0000FFFF, 1'b1);
    wr(BS_A, 32'h1F);
    chk("ro_btn", BS_A, 32'h4, 1'b1);
    chk("final_count", PC_A, 32'h1, 1'b1);

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending observations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL: %0d miscompares", n_err);
      $fatal(1);
    end
    $finish;
  end

endmodule
